// File: rtl/modport_fifo_pkg.sv
// Shared constants and types for the modport_fifo byte FIFO.
package modport_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int PTR_W      = $clog2(DEPTH_DEF);

    typedef logic [DATA_W_DEF-1:0] fifo_data_t;

endpackage

// File: rtl/fifo_if.sv
// Connection bundle for agents attached to modport_fifo.
// A driver uses the DRIVER modport and a passive checker uses the MONITOR modport.
interface fifo_if #(
    parameter int DATA_W = 8
) (
    input logic clk
);

    logic              rst;
    logic              wr_rd;
    logic [DATA_W-1:0] D_in;
    logic [DATA_W-1:0] D_out;
    logic              full;
    logic              empty;
    logic              err;

    modport DRIVER  (input clk, D_out, full, empty, err, output rst, wr_rd, D_in);
    modport MONITOR (input clk, rst, wr_rd, D_in, D_out, full, empty, err);

endinterface

// File: rtl/modport_fifo_mem.sv
// Storage array for modport_fifo: one write port and one read address.
// No reset. The top level registers the read data, so the read here is
// a plain array lookup.
module modport_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Write the entry when the top level accepts a write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/modport_fifo.sv
// Single-clock byte FIFO. The wr_rd input selects one write or one read per edge.
// The full, empty and D_out outputs are registered.
// Optional feature macro: MODPORT_FIFO_ERR_EN adds a sticky overflow/underflow output named err.
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_rd,
    input  logic [DATA_W-1:0] D_in,
    output logic [DATA_W-1:0] D_out,
    output logic              full,
    output logic              empty
`ifdef MODPORT_FIFO_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH;

    logic [AW-1:0]     wp_reg, rp_reg;
    logic [AW:0]       count_reg, count_next;
    logic              full_reg, empty_reg;
    logic [DATA_W-1:0] dout_reg;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en, rd_en;

    // Accept the requested operation only when it cannot overflow or underflow.
    // The flags are registered, so they match the current count exactly.
    always_comb begin
        wr_en      = wr_rd & ~full_reg;
        rd_en      = ~wr_rd & ~empty_reg;
        count_next = count_reg;
        if (wr_en) begin
            count_next = count_reg + CNT_ONE;
        end else if (rd_en) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    // Update the pointers, count and flags. The flags are computed from the
    // next count, so they change on the same edge as the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_reg    <= '0;
            rp_reg    <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            if (wr_en) begin
                wp_reg <= wp_reg + PTR_ONE;
            end
            if (rd_en) begin
                rp_reg <= rp_reg + PTR_ONE;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_FULL);
            empty_reg <= (count_next == '0);
        end
    end

    // Capture the head entry on an accepted read. On an underflow, keep the previous value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_reg <= '0;
        end else if (rd_en) begin
            dout_reg <= rd_data;
        end
    end

    modport_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wp_reg),
        .wdata (D_in),
        .raddr (rp_reg),
        .rdata (rd_data)
    );

    assign D_out = dout_reg;
    assign full  = full_reg;
    assign empty = empty_reg;

`ifdef MODPORT_FIFO_ERR_EN
    logic err_reg;

    // Set the sticky error on a write while full or a read while empty.
    // Only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if ((wr_rd & full_reg) | (~wr_rd & empty_reg)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// Self-checking bench for modport_fifo.
// The reference model is a queue: a write pushes to the back, a read pops from the front,
// and the capacity is DEPTH.
module tb_modport_fifo;
    import modport_fifo_pkg::*;

    localparam int DEPTH = DEPTH_DEF;

`ifdef MODPORT_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    fifo_if #(.DATA_W(DATA_W_DEF)) ifc (.clk(clk));

    modport_fifo #(
        .DATA_W (DATA_W_DEF),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (ifc.rst),
        .wr_rd (ifc.wr_rd),
        .D_in  (ifc.D_in),
        .D_out (ifc.D_out),
        .full  (ifc.full),
        .empty (ifc.empty)
`ifdef MODPORT_FIFO_ERR_EN
        ,
        .err   (ifc.err)
`endif
    );

`ifndef MODPORT_FIFO_ERR_EN
    assign ifc.err = 1'b0;
`endif

    // Reference model state.
    fifo_data_t q[$];
    fifo_data_t dout_m;
    logic       err_m;

    int n_cmp = 0;
    int n_bad = 0;

    // Apply one operation on the next rising edge, then update the model.
    // Outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic wr, input fifo_data_t data);
        ifc.wr_rd = wr;
        ifc.D_in  = data;
        @(posedge clk);
        #1;
        if (wr) begin
            if (q.size() < DEPTH) q.push_back(data);
            else err_m = err_m | ERR_EN;
        end else begin
            if (q.size() > 0) dout_m = q.pop_front();
            else err_m = err_m | ERR_EN;
        end
        $display("[%0t] %s din=%h dout=%h full=%b empty=%b err=%b model_cnt=%0d",
                 $time, wr ? "WR" : "RD", data, ifc.D_out, ifc.full, ifc.empty, ifc.err, q.size());
    endtask

    // Hold reset for the given number of cycles, then release it 1 time unit after an edge.
    task automatic hold_reset(input int cycles);
        ifc.rst = 1'b1;
        q.delete();
        dout_m = '0;
        err_m  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        ifc.rst = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset(2);
        n_cmp++;
        if ({ifc.D_out, ifc.full, ifc.empty, ifc.err} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset: dout/full/empty/err got %h/%b/%b/%b want 00/0/1/0",
                     ifc.D_out, ifc.full, ifc.empty, ifc.err);
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 8'hA5);
        n_cmp++;
        if ({ifc.full, ifc.empty} !== 2'b00) begin
            n_bad++;
            $display("FAIL write_read_wr: full/empty got %b/%b want 0/0", ifc.full, ifc.empty);
        end
        drive(1'b0, 8'h00);
        n_cmp++;
        if ({ifc.D_out, ifc.empty} !== {8'hA5, 1'b1}) begin
            n_bad++;
            $display("FAIL write_read_rd: dout/empty got %h/%b want a5/1", ifc.D_out, ifc.empty);
        end
    endtask

    task automatic test_fill_order();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, fifo_data_t'(i));
            n_cmp++;
            if ({ifc.full, ifc.empty} !== {(i == DEPTH - 1), 1'b0}) begin
                n_bad++;
                $display("FAIL fill_wr%0d: full/empty got %b/%b want %b/0",
                         i, ifc.full, ifc.empty, (i == DEPTH - 1));
            end
        end
        drive(1'b1, 8'hFF);
        n_cmp++;
        if ({ifc.full, ifc.err} !== {1'b1, ERR_EN}) begin
            n_bad++;
            $display("FAIL overflow: full/err got %b/%b want 1/%b", ifc.full, ifc.err, ERR_EN);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00);
            n_cmp++;
            if ({ifc.D_out, ifc.full, ifc.empty} !== {fifo_data_t'(i), 1'b0, (i == DEPTH - 1)}) begin
                n_bad++;
                $display("FAIL order_rd%0d: dout/full/empty got %h/%b/%b want %h/0/%b",
                         i, ifc.D_out, ifc.full, ifc.empty, fifo_data_t'(i), (i == DEPTH - 1));
            end
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, 8'h00);
        n_cmp++;
        if ({ifc.D_out, ifc.full, ifc.empty, ifc.err} !== {dout_m, 1'b0, 1'b1, err_m}) begin
            n_bad++;
            $display("FAIL underflow: dout/full/empty/err got %h/%b/%b/%b want %h/0/1/%b",
                     ifc.D_out, ifc.full, ifc.empty, ifc.err, dout_m, err_m);
        end
        drive(1'b1, 8'h77);
        drive(1'b0, 8'h00);
        n_cmp++;
        if ({ifc.D_out, ifc.empty} !== {8'h77, 1'b1}) begin
            n_bad++;
            $display("FAIL after_underflow: dout/empty got %h/%b want 77/1", ifc.D_out, ifc.empty);
        end
    endtask

    task automatic test_wraparound();
        for (int i = 0; i < 10; i++) drive(1'b1, fifo_data_t'($urandom));
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'h00);
            n_cmp++;
            if ({ifc.D_out, ifc.empty} !== {dout_m, (q.size() == 0)}) begin
                n_bad++;
                $display("FAIL wrap_pre_rd%0d: dout/empty got %h/%b want %h/%b",
                         i, ifc.D_out, ifc.empty, dout_m, (q.size() == 0));
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, fifo_data_t'(8'h30 + i));
            n_cmp++;
            if (ifc.full !== (i == DEPTH - 1)) begin
                n_bad++;
                $display("FAIL wrap_wr%0d: full got %b want %b", i, ifc.full, (i == DEPTH - 1));
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00);
            n_cmp++;
            if ({ifc.D_out, ifc.empty} !== {fifo_data_t'(8'h30 + i), (i == DEPTH - 1)}) begin
                n_bad++;
                $display("FAIL wrap_rd%0d: dout/empty got %h/%b want %h/%b",
                         i, ifc.D_out, ifc.empty, fifo_data_t'(8'h30 + i), (i == DEPTH - 1));
            end
        end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, fifo_data_t'(8'h50 + i));
        drive(1'b0, 8'h00);
        // Pulse reset between edges. The outputs must change without a clock edge.
        #1;
        ifc.rst = 1'b1;
        #1;
        q.delete();
        dout_m = '0;
        err_m  = 1'b0;
        n_cmp++;
        if ({ifc.D_out, ifc.full, ifc.empty, ifc.err} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL midreset_async: dout/full/empty/err got %h/%b/%b/%b want 00/0/1/0",
                     ifc.D_out, ifc.full, ifc.empty, ifc.err);
        end
        #1;
        ifc.rst = 1'b0;
        drive(1'b0, 8'h00);
        n_cmp++;
        if ({ifc.D_out, ifc.empty, ifc.err} !== {8'h00, 1'b1, ERR_EN}) begin
            n_bad++;
            $display("FAIL midreset_read: dout/empty/err got %h/%b/%b want 00/1/%b",
                     ifc.D_out, ifc.empty, ifc.err, ERR_EN);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 99) < 55), fifo_data_t'($urandom));
            n_cmp++;
            if ({ifc.D_out, ifc.full, ifc.empty, ifc.err} !==
                {dout_m, (q.size() == DEPTH), (q.size() == 0), err_m}) begin
                n_bad++;
                $display("FAIL random%0d: dout/full/empty/err got %h/%b/%b/%b want %h/%b/%b/%b",
                         i, ifc.D_out, ifc.full, ifc.empty, ifc.err,
                         dout_m, (q.size() == DEPTH), (q.size() == 0), err_m);
            end
        end
    endtask

    initial begin
        ifc.rst   = 1'b1;
        ifc.wr_rd = 1'b0;
        ifc.D_in  = '0;
        dout_m    = '0;
        err_m     = 1'b0;
        test_reset();
        test_write_read();
        test_fill_order();
        test_underflow();
        test_wraparound();
        test_midstream_reset();
        test_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
